load_store_unit: RTL and testbench

Initiator-side memory access controller for the MIPS datapath: it sits between the MEM pipeline stage and the word-addressed, single-port data memory. It accepts byte, halfword and word loads and stores at byte addresses, drives the memory's read/write strobes, extracts and sign- or zero-extends load data, and performs read-modify-write for sub-word stores. The pipeline stalls on `Busy`.

---
 rtl/load_store_unit_pkg.sv | 19 +
 rtl/load_store_unit_if.sv | 42 ++++
 rtl/load_store_unit_lane_mux.sv | 48 ++++
 rtl/load_store_unit.sv | 148 ++++++++++++++
 tb/tb_load_store_unit.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states
// and the default data memory depth.
package lsu_pkg;

    localparam int MEM_WORDS_DEFAULT = 1000;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_WRITE,
        S_FIN
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request bundle and memory-side bus bundle of the LSU.
// The master drives the request or the bus, the slave answers it.
interface lsu_req_if;
    logic        Req;
    logic        Req_we;
    logic [1:0]  Req_size;
    logic        Req_unsigned;
    logic [31:0] Req_addr;
    logic [31:0] Req_wdata;
    logic        Busy;
    logic        Done;
    logic        Fault;
    logic [31:0] Load_data;

    modport master (
        output Req, Req_we, Req_size, Req_unsigned, Req_addr, Req_wdata,
        input  Busy, Done, Fault, Load_data
    );

    modport slave (
        input  Req, Req_we, Req_size, Req_unsigned, Req_addr, Req_wdata,
        output Busy, Done, Fault, Load_data
    );
endinterface

interface lsu_mem_if;
    logic [31:0] Mem_address;
    logic [31:0] Mem_write_data;
    logic        Mem_read;
    logic        Mem_write;
    logic [31:0] Mem_read_data;

    modport master (
        output Mem_address, Mem_write_data, Mem_read, Mem_write,
        input  Mem_read_data
    );

    modport slave (
        input  Mem_address, Mem_write_data, Mem_read, Mem_write,
        output Mem_read_data
    );
endinterface

// File: rtl/load_store_unit_lane_mux.sv
// Big-endian lane select: extracts/extends load lanes and merges
// store lanes into the word read back from memory.
module lsu_lane_mux
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    output logic [31:0] ld_o,
    output logic [31:0] st_o
);

    logic [4:0]  sh;
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        sh   = 5'd0;
        b    = 8'd0;
        h    = 16'd0;
        ld_o = rdata_i;
        st_o = wdata_i;
        unique case (size_i)
            SZ_BYTE: begin
                // offset 0 is the most significant byte
                sh   = {~off_i, 3'b000};
                b    = 8'(rdata_i >> sh);
                ld_o = {{24{~uns_i & b[7]}}, b};
                st_o = (rdata_i & ~(32'h0000_00FF << sh))
                     | ({24'd0, wdata_i[7:0]} << sh);
            end
            SZ_HALF: begin
                sh   = {~off_i[1], 4'b0000};
                h    = 16'(rdata_i >> sh);
                ld_o = {{16{~uns_i & h[15]}}, h};
                st_o = (rdata_i & ~(32'h0000_FFFF << sh))
                     | ({16'd0, wdata_i[15:0]} << sh);
            end
            default: begin
                ld_o = rdata_i;
                st_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller for a word-addressed single-port
// data memory, with read-modify-write for sub-word stores.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic      Clk,
    input  logic      Rst_n,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [29:0] idx_q;
    logic [31:0] wdata_q;
    logic [31:0] mwd_q;
    logic [31:0] ld_q;
    logic        done_q;
    logic        fault_q;

    logic        accept;
    logic        bad;
    logic        rd;
    logic        wr;
    logic [31:0] ld_ext;
    logic [31:0] st_merge;

    assign accept = req.Req & (state_q == S_IDLE);

    always_comb begin
        bad = 1'b0;
        unique case (1'b1)
            (req.Req_size == 2'b11):                  bad = 1'b1;
            (req.Req_size == SZ_HALF):                bad = req.Req_addr[0];
            (req.Req_size == SZ_WORD):                bad = |req.Req_addr[1:0];
            default:                                  bad = 1'b0;
        endcase
        if ({2'b00, req.Req_addr[31:2]} >= 32'(MEM_WORDS)) begin
            bad = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rd      = 1'b0;
        wr      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bad) begin
                        state_d = S_FIN;
                    end else if (req.Req_we && req.Req_size == SZ_WORD) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                rd      = 1'b1;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                state_d = we_q ? S_WRITE : S_FIN;
            end
            S_WRITE: begin
                wr      = 1'b1;
                state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    lsu_lane_mux u_lane (
        .rdata_i (mem.Mem_read_data),
        .wdata_i (wdata_q),
        .off_i   (off_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .ld_o    (ld_ext),
        .st_o    (st_merge)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == S_FIN);
            fault_q <= accept & bad;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            off_q   <= 2'd0;
            idx_q   <= 30'd0;
            wdata_q <= 32'd0;
            mwd_q   <= 32'd0;
            ld_q    <= 32'd0;
        end else begin
            if (accept) begin
                we_q    <= req.Req_we;
                uns_q   <= req.Req_unsigned;
                size_q  <= req.Req_size;
                off_q   <= req.Req_addr[1:0];
                idx_q   <= req.Req_addr[31:2];
                wdata_q <= req.Req_wdata;
                if (req.Req_we && req.Req_size == SZ_WORD) begin
                    mwd_q <= req.Req_wdata;
                end
            end
            if (state_q == S_CAPTURE) begin
                if (we_q) begin
                    mwd_q <= st_merge;
                end else begin
                    ld_q <= ld_ext;
                end
            end
        end
    end

    assign req.Busy      = (state_q != S_IDLE);
    assign req.Done      = done_q;
    assign req.Fault     = fault_q & done_q;
    assign req.Load_data = ld_q;

    assign mem.Mem_address    = {2'b00, idx_q};
    assign mem.Mem_write_data = mwd_q;
    assign mem.Mem_read       = rd;
    assign mem.Mem_write      = wr;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-array model.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_req_if rq ();
    lsu_mem_if mb ();

    load_store_unit #(.MEM_WORDS(1000)) dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .req   (rq),
        .mem   (mb)
    );

    logic [31:0] mem [0:999];
    logic [31:0] rdq = 32'd0;
    logic [7:0]  rb  [0:3999];
    logic [31:0] last_ld = 32'd0;
    int n_cmp = 0;
    int n_bad = 0;
    int ovl = 0;
    int wr_total = 0;

    assign mb.Mem_read_data = rdq;

    always @(posedge clk) begin
        if (mb.Mem_read) begin
            rdq <= (mb.Mem_address < 1000) ? mem[mb.Mem_address[9:0]] : 32'd0;
        end else if (mb.Mem_write && mb.Mem_address < 1000) begin
            mem[mb.Mem_address[9:0]] <= mb.Mem_write_data;
        end
        if (mb.Mem_read && mb.Mem_write) ovl++;
        if (mb.Mem_write) wr_total++;
    end

    function automatic logic ref_fault(logic [1:0] sz, logic [31:0] a);
        return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0)
            || (sz == 2'd2 && a % 4 != 0) || (a / 4) >= 1000;
    endfunction

    function automatic logic [31:0] ref_load(logic [1:0] sz, logic uns,
                                             logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (sz == 2'd0) begin
            v = 32'(rb[a]);
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = 32'(rb[a]) * 256 + 32'(rb[a+1]);
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = ((32'(rb[a]) * 256 + 32'(rb[a+1])) * 256
                + 32'(rb[a+2])) * 256 + 32'(rb[a+3]);
        end
        return v;
    endfunction

    task automatic ref_store(logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
        if (sz == 2'd0) begin
            rb[a] = wd[7:0];
        end else if (sz == 2'd1) begin
            rb[a]   = wd[15:8];
            rb[a+1] = wd[7:0];
        end else begin
            rb[a]   = wd[31:24];
            rb[a+1] = wd[23:16];
            rb[a+2] = wd[15:8];
            rb[a+3] = wd[7:0];
        end
    endtask

    function automatic logic [31:0] ref_word(int i);
        return {rb[4*i], rb[4*i+1], rb[4*i+2], rb[4*i+3]};
    endfunction

    task automatic init_mem();
        logic [31:0] w;
        for (int i = 0; i < 1000; i++) begin
            w = (i == 4) ? 32'h8899_AABB : $urandom;
            mem[i] = w;
            rb[4*i]   = w[31:24];
            rb[4*i+1] = w[23:16];
            rb[4*i+2] = w[15:8];
            rb[4*i+3] = w[7:0];
        end
    endtask

    task automatic run_req(
        input  logic        we,
        input  logic [1:0]  sz,
        input  logic        uns,
        input  logic [31:0] a,
        input  logic [31:0] wd,
        output int          dc,
        output int          rc,
        output int          wc,
        output int          rn,
        output int          wn,
        output logic        flt,
        output logic [31:0] ld,
        output logic [31:0] wa,
        output logic [31:0] wdo,
        output logic        bok
    );
        dc = -1; rc = -1; wc = -1; rn = 0; wn = 0;
        flt = 1'b0; ld = 32'd0; wa = 32'd0; wdo = 32'd0; bok = 1'b1;
        @(negedge clk);
        rq.Req = 1'b1;
        rq.Req_we = we;
        rq.Req_size = sz;
        rq.Req_unsigned = uns;
        rq.Req_addr = a;
        rq.Req_wdata = wd;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rq.Req = 1'b0;
                rq.Req_we = ~we;
                rq.Req_size = 2'($urandom_range(0, 3));
                rq.Req_unsigned = ~uns;
                rq.Req_addr = $urandom;
                rq.Req_wdata = $urandom;
            end
            if (rq.Busy !== 1'b1) bok = 1'b0;
            if (mb.Mem_read === 1'b1) begin
                rn++;
                if (rc < 0) rc = k;
            end
            if (mb.Mem_write === 1'b1) begin
                wn++;
                if (wc < 0) wc = k;
                wa = mb.Mem_address;
                wdo = mb.Mem_write_data;
            end
            if (rq.Done === 1'b1) begin
                dc = k;
                flt = rq.Fault;
                ld = rq.Load_data;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [7:0] got;
        got = {rq.Busy, rq.Done, rq.Fault, mb.Mem_read, mb.Mem_write,
               |rq.Load_data, |mb.Mem_address, |mb.Mem_write_data};
        n_cmp++;
        if (got !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_in: got %b want 00000000", got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        got = {rq.Busy, rq.Done, rq.Fault, mb.Mem_read, mb.Mem_write,
               |rq.Load_data, |mb.Mem_address, |mb.Mem_write_data};
        n_cmp++;
        if (got !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_out: got %b want 00000000", got);
        end
    endtask

    task automatic test_loads();
        logic [1:0]  szs [3] = '{2'd0, 2'd0, 2'd1};
        logic        uss [3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] ads [3] = '{32'h12, 32'h12, 32'h10};
        logic [31:0] exp [3] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'h0000_8899};
        int dc, rc, wc, rn, wn;
        logic flt, bok;
        logic [31:0] ld, wa, wdo;
        for (int i = 0; i < 3; i++) begin
            run_req(1'b0, szs[i], uss[i], ads[i], 32'd0,
                    dc, rc, wc, rn, wn, flt, ld, wa, wdo, bok);
            n_cmp++;
            if (dc !== 3 || rc !== 1 || wn !== 0 || flt !== 1'b0) begin
                n_bad++;
                $display("FAIL load%0d_timing: done %0d rd %0d wr# %0d flt %b want 3 1 0 0",
                         i, dc, rc, wn, flt);
            end
            n_cmp++;
            if (ld !== exp[i]) begin
                n_bad++;
                $display("FAIL load%0d_data: got %h want %h", i, ld, exp[i]);
            end
            last_ld = exp[i];
        end
    endtask

    task automatic test_sub_store();
        int dc, rc, wc, rn, wn;
        logic flt, bok;
        logic [31:0] ld, wa, wdo;
        run_req(1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_1234,
                dc, rc, wc, rn, wn, flt, ld, wa, wdo, bok);
        ref_store(2'd1, 32'h10, 32'h0000_1234);
        n_cmp++;
        if (rc !== 1 || wc !== 3 || dc !== 4 || rn !== 1 || wn !== 1) begin
            n_bad++;
            $display("FAIL sh_timing: rd %0d wr %0d done %0d want 1 3 4", rc, wc, dc);
        end
        n_cmp++;
        if (wa !== 32'd4 || wdo !== 32'h1234_AABB) begin
            n_bad++;
            $display("FAIL sh_write: addr %h data %h want 4 1234aabb", wa, wdo);
        end
        run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0,
                dc, rc, wc, rn, wn, flt, ld, wa, wdo, bok);
        n_cmp++;
        if (ld !== 32'h1234_AABB || dc !== 3) begin
            n_bad++;
            $display("FAIL lw_after_sh: got %h done %0d want 1234aabb 3", ld, dc);
        end
        last_ld = 32'h1234_AABB;
    endtask

    task automatic test_word_store();
        int dc, rc, wc, rn, wn;
        logic flt, bok;
        logic [31:0] ld, wa, wdo;
        run_req(1'b1, 2'd2, 1'b0, 32'h14, 32'hDEAD_BEEF,
                dc, rc, wc, rn, wn, flt, ld, wa, wdo, bok);
        ref_store(2'd2, 32'h14, 32'hDEAD_BEEF);
        n_cmp++;
        if (rn !== 0 || wc !== 1 || dc !== 2 || !bok) begin
            n_bad++;
            $display("FAIL sw_timing: rd# %0d wr %0d done %0d busy %b want 0 1 2 1",
                     rn, wc, dc, bok);
        end
        n_cmp++;
        if (wa !== 32'd5 || wdo !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL sw_write: addr %h data %h want 5 deadbeef", wa, wdo);
        end
    endtask

    task automatic test_faults();
        logic [1:0]  szs [3] = '{2'd2, 2'd1, 2'd2};
        logic [31:0] ads [3] = '{32'h13, 32'h11, 32'hFA0};
        int dc, rc, wc, rn, wn;
        logic flt, bok;
        logic [31:0] ld, wa, wdo;
        for (int i = 0; i < 3; i++) begin
            run_req(1'b0, szs[i], 1'b0, ads[i], 32'd0,
                    dc, rc, wc, rn, wn, flt, ld, wa, wdo, bok);
            n_cmp++;
            if (flt !== 1'b1 || dc !== 1 || rn + wn !== 0) begin
                n_bad++;
                $display("FAIL fault%0d: flt %b done %0d strobes %0d want 1 1 0",
                         i, flt, dc, rn + wn);
            end
            n_cmp++;
            if (ld !== last_ld) begin
                n_bad++;
                $display("FAIL fault%0d_ld: got %h want %h", i, ld, last_ld);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_a, exp_b;
        logic [8:0]  rdm, dnm, bzm;
        logic [31:0] ld3, ld7;
        exp_a = ref_load(2'd2, 1'b0, 32'h10);
        exp_b = ref_load(2'd1, 1'b1, 32'h16);
        rdm = '0; dnm = '0; bzm = '0; ld3 = '0; ld7 = '0;
        @(negedge clk);
        rq.Req = 1'b1; rq.Req_we = 1'b0; rq.Req_size = 2'd2;
        rq.Req_unsigned = 1'b0; rq.Req_addr = 32'h10;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rq.Req_size = 2'd1; rq.Req_unsigned = 1'b1; rq.Req_addr = 32'h16;
            end
            rdm[k] = mb.Mem_read;
            dnm[k] = rq.Done;
            bzm[k] = rq.Busy;
            if (k == 3) ld3 = rq.Load_data;
            if (k == 7) ld7 = rq.Load_data;
            if (k == 5) rq.Req = 1'b0;
        end
        n_cmp++;
        if (rdm !== 9'b000100010 || dnm !== 9'b010001000) begin
            n_bad++;
            $display("FAIL b2b_seq: rd %b done %b want 000100010 010001000", rdm, dnm);
        end
        n_cmp++;
        if (bzm !== 9'b011101110) begin
            n_bad++;
            $display("FAIL b2b_busy: got %b want 011101110", bzm);
        end
        n_cmp++;
        if (ld3 !== exp_a || ld7 !== exp_b) begin
            n_bad++;
            $display("FAIL b2b_data: got %h %h want %h %h", ld3, ld7, exp_a, exp_b);
        end
        last_ld = exp_b;
    endtask

    task automatic test_reset_mid();
        int w0, dc, rc, wc, rn, wn;
        logic flt, bok;
        logic [31:0] ld, wa, wdo, exp;
        @(negedge clk);
        rq.Req = 1'b1; rq.Req_we = 1'b1; rq.Req_size = 2'd0;
        rq.Req_unsigned = 1'b0; rq.Req_addr = 32'h21; rq.Req_wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        rq.Req = 1'b0;
        @(negedge clk);
        w0 = wr_total;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rq.Busy, mb.Mem_write, mb.Mem_read, rq.Done} !== 4'b0000) begin
            n_bad++;
            $display("FAIL rst_mid: busy/wr/rd/done %b want 0000",
                     {rq.Busy, mb.Mem_write, mb.Mem_read, rq.Done});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        last_ld = 32'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (wr_total !== w0 || rq.Done !== 1'b0 || mem[8] !== ref_word(8)) begin
            n_bad++;
            $display("FAIL rst_mid_mem: writes %0d word %h want %0d %h",
                     wr_total - w0, mem[8], 0, ref_word(8));
        end
        exp = ref_load(2'd2, 1'b0, 32'h20);
        run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'd0,
                dc, rc, wc, rn, wn, flt, ld, wa, wdo, bok);
        n_cmp++;
        if (ld !== exp) begin
            n_bad++;
            $display("FAIL rst_mid_lw: got %h want %h", ld, exp);
        end
        last_ld = exp;
    endtask

    task automatic test_random();
        int dc, rc, wc, rn, wn, r, wi, edc, ern, ewn;
        logic flt, bok, we, uns, f;
        logic [1:0] sz;
        logic [31:0] ld, wa, wdo, a, wd, eld;
        for (int n = 0; n < 300; n++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            r   = $urandom_range(0, 9);
            sz  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            wi  = ($urandom_range(0, 7) == 0) ? $urandom_range(995, 1005)
                                               : $urandom_range(0, 15);
            a   = 32'(wi) * 4 + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a = a - (a % 2);
                if (sz == 2'd2) a = a - (a % 4);
            end
            wd  = $urandom;
            f   = ref_fault(sz, a);
            edc = f ? 1 : (!we ? 3 : (sz == 2'd2 ? 2 : 4));
            ern = (f || (we && sz == 2'd2)) ? 0 : 1;
            ewn = (!f && we) ? 1 : 0;
            eld = (!f && !we) ? ref_load(sz, uns, a) : last_ld;
            run_req(we, sz, uns, a, wd,
                    dc, rc, wc, rn, wn, flt, ld, wa, wdo, bok);
            n_cmp++;
            if (dc !== edc || flt !== f || rn !== ern || wn !== ewn || !bok) begin
                n_bad++;
                $display("FAIL rnd%0d_ctl: done %0d flt %b rd %0d wr %0d busy %b want %0d %b %0d %0d 1",
                         n, dc, flt, rn, wn, bok, edc, f, ern, ewn);
            end
            n_cmp++;
            if (ld !== eld) begin
                n_bad++;
                $display("FAIL rnd%0d_ld: got %h want %h", n, ld, eld);
            end
            last_ld = eld;
            if (ewn == 1) begin
                ref_store(sz, a, wd);
                n_cmp++;
                if (wa !== a / 4 || wdo !== ref_word(wi)) begin
                    n_bad++;
                    $display("FAIL rnd%0d_wr: addr %h data %h want %h %h",
                             n, wa, wdo, a / 4, ref_word(wi));
                end
            end
        end
    endtask

    task automatic test_final();
        int bad_words;
        bad_words = 0;
        for (int i = 0; i < 1000; i++) begin
            if (mem[i] !== ref_word(i)) bad_words++;
        end
        n_cmp++;
        if (bad_words !== 0) begin
            n_bad++;
            $display("FAIL mem_image: %0d words differ want 0", bad_words);
        end
        n_cmp++;
        if (ovl !== 0) begin
            n_bad++;
            $display("FAIL strobe_overlap: got %0d want 0", ovl);
        end
    endtask

    initial begin
        rq.Req = 1'b0;
        rq.Req_we = 1'b0;
        rq.Req_size = 2'd0;
        rq.Req_unsigned = 1'b0;
        rq.Req_addr = 32'd0;
        rq.Req_wdata = 32'd0;
        init_mem();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_loads();
        test_sub_store();
        test_word_store();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_final();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
